// File: rtl/ip_handler_top_hls_deadlock_pkg.sv
// Shared types and elaboration helpers for the deadlock report unit:
// the report FSM state encoding and the width helpers used to size ports.
package ip_handler_top_hls_deadlock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ORIGIN = 3'd1,
        ST_TRACE  = 3'd2,
        ST_REPORT = 3'd3,
        ST_HALT   = 3'd4
    } dl_state_e;

    // Ceiling log2, usable in constant expressions (clog2(1) == 0).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/ip_handler_top_hls_deadlock_prio_enc.sv
// Lowest-index-wins priority encoder: reports the smallest set request bit
// and whether any request is present at all.
module ip_handler_top_hls_deadlock_prio_enc
    import ip_handler_top_hls_deadlock_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ip_handler_top_hls_deadlock_report_unit.sv
// Deadlock report unit: picks an origin process, injects a token, waits for it
// to come back (or gives up), then publishes a one-shot report and halts.
module ip_handler_top_hls_deadlock_report_unit
    import ip_handler_top_hls_deadlock_pkg::*;
#(
    parameter int  PROC_NUM = 4,
    parameter int  TIMEOUT  = 64,
    localparam int IDX_W    = idx_width(PROC_NUM),
    localparam int CNT_W    = clog2(TIMEOUT + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_in_vec,
    output logic                dl_detect_bcast,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [IDX_W-1:0]    report_idx,
    output logic [CNT_W-1:0]    report_cycles,
    output logic                report_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    dl_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bcast_q;
    logic [IDX_W-1:0] rep_idx_q, rep_idx_d;
    logic [CNT_W-1:0] rep_cycles_q, rep_cycles_d;
    logic             rep_timeout_q, rep_timeout_d;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;
    logic             token_back;

    ip_handler_top_hls_deadlock_prio_enc #(
        .N     (PROC_NUM),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req_i   (dl_in_vec),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    // Only the origin's own bit matters once a trace is under way.
    assign token_back = dl_in_vec[idx_q];

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        rep_idx_d     = rep_idx_q;
        rep_cycles_d  = rep_cycles_q;
        rep_timeout_d = rep_timeout_q;
        origin_vec    = '0;
        token_clear   = 1'b0;
        report_valid  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    idx_d   = enc_idx;
                    state_d = ST_ORIGIN;
                end
            end
            ST_ORIGIN: begin
                origin_vec[idx_q] = 1'b1;
                cnt_d             = '0;
                state_d           = ST_TRACE;
            end
            ST_TRACE: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A return on the last allowed cycle still counts as a return.
                if (token_back) begin
                    token_clear   = 1'b1;
                    rep_idx_d     = idx_q;
                    rep_cycles_d  = cnt_q;
                    rep_timeout_d = 1'b0;
                    state_d       = ST_REPORT;
                end else if (cnt_q == CNT_LAST) begin
                    rep_idx_d     = idx_q;
                    rep_cycles_d  = CNT_MAX;
                    rep_timeout_d = 1'b1;
                    state_d       = ST_REPORT;
                end
            end
            ST_REPORT: begin
                report_valid = 1'b1;
                if (report_ready) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            bcast_q       <= 1'b0;
            rep_idx_q     <= '0;
            rep_cycles_q  <= '0;
            rep_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            bcast_q       <= (state_d != ST_IDLE);
            rep_idx_q     <= rep_idx_d;
            rep_cycles_q  <= rep_cycles_d;
            rep_timeout_q <= rep_timeout_d;
        end
    end

    assign dl_detect_bcast = bcast_q;
    assign report_idx      = rep_idx_q;
    assign report_cycles   = rep_cycles_q;
    assign report_timeout  = rep_timeout_q;

    // Structural invariants of the protocol, checked in simulation only.
    a_origin_onehot0 : assert property (@(posedge clock) disable iff (!reset)
        $onehot0(origin_vec));
    a_clear_in_trace : assert property (@(posedge clock) disable iff (!reset)
        token_clear |-> (state_q == ST_TRACE));
    a_report_stable  : assert property (@(posedge clock) disable iff (!reset)
        (report_valid && !report_ready) |=> (report_valid
            && $stable(report_idx) && $stable(report_cycles) && $stable(report_timeout)));

endmodule
